// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter fronted by a small TX FIFO.
// Frames are START, DATA_BITS data bits (LSB first), optional parity and
// STOP_BITS stop bits; queued frames stream back-to-back with no idle gap.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_Tx_DV,
    input  logic [DATA_BITS-1:0]          i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done
);

    localparam int CLK_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Shared index for data bits (up to 9) and stop bits (up to 2).
    localparam int IDX_W = 4;

    localparam logic [CLK_W-1:0] LAST_CLK  = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Parity bit for the configured mode: even = XOR of data, odd = its inverse.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        logic p;
        if (PARITY == 1) begin
            p = ~(^d);
        end else begin
            p = ^d;
        end
        return p;
    endfunction

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    // Transmit engine
    state_t               r_state;
    logic [CLK_W-1:0]     r_clk_cnt;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic                 r_serial;
    logic                 r_active;
    logic                 r_done;

    state_t               w_state_nxt;
    logic [CLK_W-1:0]     w_clk_nxt;
    logic [IDX_W-1:0]     w_bit_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 w_parity_nxt;
    logic                 w_serial_nxt;
    logic                 w_active_nxt;
    logic                 w_done_nxt;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_ready;
    logic                 w_have_data;
    logic                 w_bit_end;
    logic [DATA_BITS-1:0] w_head;

    assign w_ready     = (r_count < DEPTH_C);
    assign w_push      = i_Tx_DV & w_ready;
    assign w_have_data = (r_count != '0);
    assign w_bit_end   = (r_clk_cnt == LAST_CLK);
    assign w_head      = r_mem[r_rd_ptr];

    assign o_Tx_Ready   = w_ready;
    assign o_Fifo_Count = r_count;
    assign o_Tx_Serial  = r_serial;
    assign o_Tx_Active  = r_active;
    assign o_Tx_Done    = r_done;

    // FIFO data array: written on an accepted push, contents need no reset.
    always_ff @(posedge i_Clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_Tx_Byte;
        end
    end

    // FIFO pointers and occupancy; a push and pop on the same edge cancel out.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Transmit state register and registered line outputs.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_serial  <= 1'b1;
            r_active  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_parity  <= w_parity_nxt;
            r_serial  <= w_serial_nxt;
            r_active  <= w_active_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Next-state logic; the line value is computed for the state being entered
    // so the registered output changes on the same edge as the state.
    always_comb begin
        w_state_nxt  = r_state;
        w_clk_nxt    = r_clk_cnt;
        w_bit_nxt    = r_bit_idx;
        w_shift_nxt  = r_shift;
        w_parity_nxt = r_parity;
        w_serial_nxt = r_serial;
        w_active_nxt = r_active;
        w_done_nxt   = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_clk_nxt = '0;
                w_bit_nxt = '0;
                if (w_have_data) begin
                    w_pop        = 1'b1;
                    w_shift_nxt  = w_head;
                    w_parity_nxt = parity_bit(w_head);
                    w_state_nxt  = S_START;
                    w_serial_nxt = 1'b0;
                    w_active_nxt = 1'b1;
                end else begin
                    w_serial_nxt = 1'b1;
                    w_active_nxt = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_clk_nxt    = '0;
                    w_bit_nxt    = '0;
                    w_state_nxt  = S_DATA;
                    w_serial_nxt = r_shift[0];
                end else begin
                    w_clk_nxt = r_clk_cnt + CLK_W'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_clk_nxt   = '0;
                    w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};
                    if (r_bit_idx == LAST_DATA) begin
                        w_bit_nxt = '0;
                        if (PARITY != 0) begin
                            w_state_nxt  = S_PARITY;
                            w_serial_nxt = r_parity;
                        end else begin
                            w_state_nxt  = S_STOP;
                            w_serial_nxt = 1'b1;
                        end
                    end else begin
                        w_bit_nxt    = r_bit_idx + IDX_W'(1);
                        w_serial_nxt = r_shift[1];
                    end
                end else begin
                    w_clk_nxt = r_clk_cnt + CLK_W'(1);
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_clk_nxt    = '0;
                    w_bit_nxt    = '0;
                    w_state_nxt  = S_STOP;
                    w_serial_nxt = 1'b1;
                end else begin
                    w_clk_nxt = r_clk_cnt + CLK_W'(1);
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_clk_nxt = '0;
                    if (r_bit_idx == LAST_STOP) begin
                        w_done_nxt = 1'b1;
                        w_bit_nxt  = '0;
                        if (w_have_data) begin
                            // Chain straight into the next frame.
                            w_pop        = 1'b1;
                            w_shift_nxt  = w_head;
                            w_parity_nxt = parity_bit(w_head);
                            w_state_nxt  = S_START;
                            w_serial_nxt = 1'b0;
                            w_active_nxt = 1'b1;
                        end else begin
                            w_state_nxt  = S_IDLE;
                            w_serial_nxt = 1'b1;
                            w_active_nxt = 1'b0;
                        end
                    end else begin
                        w_bit_nxt = r_bit_idx + IDX_W'(1);
                    end
                end else begin
                    w_clk_nxt = r_clk_cnt + CLK_W'(1);
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_clk_nxt    = '0;
                w_bit_nxt    = '0;
                w_serial_nxt = 1'b1;
                w_active_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: four configurations share one
// stimulus stream and are compared every cycle against a frame-level model.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int NCFG  = 4;

    // Configurations: 0 = 8N1, 1 = 8E1, 2 = 8O1, 3 = 7N2.
    function automatic int cfg_db(input int g);
        return (g == 3) ? 7 : 8;
    endfunction
    function automatic int cfg_par(input int g);
        return (g == 1) ? 2 : ((g == 2) ? 1 : 0);
    endfunction
    function automatic int cfg_sb(input int g);
        return (g == 3) ? 2 : 1;
    endfunction
    function automatic int frame_cycles(input int g);
        return (1 + cfg_db(g) + ((cfg_par(g) != 0) ? 1 : 0) + cfg_sb(g)) * CPB;
    endfunction

    logic       clk;
    logic       tb_rst;
    logic       tb_dv;
    logic [8:0] tb_byte;

    logic       w_rdy  [NCFG];
    logic [2:0] w_cnt  [NCFG];
    logic       w_ser  [NCFG];
    logic       w_act  [NCFG];
    logic       w_done [NCFG];

    int n_checks;
    int n_errors;

    // Reference model state: queue contents, current frame bit list, position.
    int mq     [NCFG][DEPTH];
    int mq_n   [NCFG];
    int fb     [NCFG][16];
    int tpos   [NCFG];
    bit busy   [NCFG];
    bit e_done [NCFG];

    // Per-frame observation records used by the directed checks.
    bit smp    [NCFG][64];
    int act_n  [NCFG];
    int done_n [NCFG];
    int low_n  [NCFG];

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int DB = cfg_db(g);
        uart_tx_fifo #(
            .CLKS_PER_BIT (CPB),
            .DATA_BITS    (DB),
            .PARITY       (cfg_par(g)),
            .STOP_BITS    (cfg_sb(g)),
            .FIFO_DEPTH   (DEPTH)
        ) u_dut (
            .i_Clock      (clk),
            .i_Reset      (tb_rst),
            .i_Tx_DV      (tb_dv),
            .i_Tx_Byte    (tb_byte[DB-1:0]),
            .o_Tx_Ready   (w_rdy[g]),
            .o_Fifo_Count (w_cnt[g]),
            .o_Tx_Serial  (w_ser[g]),
            .o_Tx_Active  (w_act[g]),
            .o_Tx_Done    (w_done[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < NCFG; g++) begin
            mq_n[g]   = 0;
            busy[g]   = 1'b0;
            tpos[g]   = 0;
            e_done[g] = 1'b0;
        end
    endtask

    // Build the list of line levels (one per bit period) for a frame.
    task automatic load_frame(input int g, input int d);
        int n;
        int ones;
        n = 0;
        fb[g][n] = 0;
        n++;
        for (int k = 0; k < cfg_db(g); k++) begin
            fb[g][n] = (d >> k) & 1;
            n++;
        end
        ones = $countones(d);
        if (cfg_par(g) == 2) begin
            fb[g][n] = ones % 2;
            n++;
        end else if (cfg_par(g) == 1) begin
            fb[g][n] = 1 - (ones % 2);
            n++;
        end
        for (int k = 0; k < cfg_sb(g); k++) begin
            fb[g][n] = 1;
            n++;
        end
    endtask

    // Advance the model across one rising edge with the given write inputs.
    task automatic model_edge(input bit dv, input logic [8:0] b);
        int pre;
        for (int g = 0; g < NCFG; g++) begin
            if (tb_rst) begin
                mq_n[g]   = 0;
                busy[g]   = 1'b0;
                tpos[g]   = 0;
                e_done[g] = 1'b0;
            end else begin
                pre       = mq_n[g];
                e_done[g] = 1'b0;
                if (busy[g]) begin
                    tpos[g]++;
                    if (tpos[g] == frame_cycles(g)) begin
                        e_done[g] = 1'b1;
                        busy[g]   = 1'b0;
                    end
                end
                if (!busy[g] && pre > 0) begin
                    load_frame(g, mq[g][0]);
                    for (int k = 0; k < DEPTH - 1; k++) mq[g][k] = mq[g][k+1];
                    mq_n[g]--;
                    busy[g] = 1'b1;
                    tpos[g] = 0;
                end
                if (dv && pre < DEPTH) begin
                    mq[g][mq_n[g]] = int'(b) & ((1 << cfg_db(g)) - 1);
                    mq_n[g]++;
                end
            end
        end
    endtask

    task automatic compare_all();
        int es;
        for (int g = 0; g < NCFG; g++) begin
            es = busy[g] ? fb[g][tpos[g] / CPB] : 1;
            check($sformatf("serial[%0d]", g), 32'(w_ser[g]), es);
            check($sformatf("active[%0d]", g), 32'(w_act[g]), int'(busy[g]));
            check($sformatf("done[%0d]", g),   32'(w_done[g]), int'(e_done[g]));
            check($sformatf("count[%0d]", g),  32'(w_cnt[g]), mq_n[g]);
            check($sformatf("ready[%0d]", g),  32'(w_rdy[g]), (mq_n[g] < DEPTH) ? 1 : 0);
        end
    endtask

    // One clock: present inputs, take the edge, then sample 2 time units later.
    task automatic step(input bit dv, input logic [8:0] b);
        tb_dv   = dv;
        tb_byte = b;
        @(posedge clk);
        #2;
        model_edge(dv, b);
        compare_all();
        tb_dv = 1'b0;
    endtask

    task automatic run_frame(input logic [8:0] b);
        for (int g = 0; g < NCFG; g++) begin
            act_n[g]  = 0;
            done_n[g] = 0;
        end
        step(1'b1, b);
        for (int s = 1; s <= 60; s++) begin
            step(1'b0, 9'h000);
            for (int g = 0; g < NCFG; g++) begin
                act_n[g]  += int'(w_act[g]);
                done_n[g] += int'(w_done[g]);
                smp[g][s]  = w_ser[g];
            end
        end
        for (int g = 0; g < NCFG; g++) begin
            check($sformatf("frame_len[%0d]", g), 32'(act_n[g]), frame_cycles(g));
            check($sformatf("frame_done[%0d]", g), 32'(done_n[g]), 1);
        end
    endtask

    initial begin
        int a5_line [10];
        int l55_line [10];
        a5_line  = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        l55_line = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 1};
        n_checks = 0;
        n_errors = 0;
        tb_rst   = 1'b1;
        tb_dv    = 1'b0;
        tb_byte  = 9'h000;
        model_reset();

        // Reset state
        repeat (3) step(1'b0, 9'h000);
        tb_rst = 1'b0;
        repeat (5) step(1'b0, 9'h000);

        // Single 0xA5 frame: 8N1 line pattern, parity bits, frame lengths
        run_frame(9'h0A5);
        for (int k = 0; k < 10; k++)
            check($sformatf("a5_bit%0d", k), 32'(smp[0][4*k+2]), a5_line[k]);
        check("even_parity", 32'(smp[1][38]), 0);
        check("odd_parity", 32'(smp[2][38]), 1);

        // Single 0x55 frame on the 7N2 configuration
        run_frame(9'h055);
        for (int k = 0; k < 10; k++)
            check($sformatf("l55_bit%0d", k), 32'(smp[3][4*k+2]), l55_line[k]);

        // Burst of six writes into a four-deep FIFO: the sixth finds it full
        for (int g = 0; g < NCFG; g++) done_n[g] = 0;
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 9'(k));
            if (k >= 5) begin
                check($sformatf("burst_cnt_w%0d", k), 32'(w_cnt[0]), 4);
                check($sformatf("burst_rdy_w%0d", k), 32'(w_rdy[0]), 0);
            end
        end
        repeat (260) begin
            step(1'b0, 9'h000);
            for (int g = 0; g < NCFG; g++) done_n[g] += int'(w_done[g]);
        end
        for (int g = 0; g < NCFG; g++)
            check($sformatf("burst_dones[%0d]", g), 32'(done_n[g]), 5);

        // Push on the same edge the STOP->START pop happens
        step(1'b1, 9'h011);
        step(1'b1, 9'h022);
        repeat (39) step(1'b0, 9'h000);
        step(1'b1, 9'h033);
        check("pushpop_cnt", 32'(w_cnt[0]), 1);
        check("pushpop_done", 32'(w_done[0]), 1);
        check("pushpop_start", 32'(w_ser[0]), 0);
        repeat (150) step(1'b0, 9'h000);

        // Reset in the DATA bits of the second of three queued frames
        step(1'b1, 9'h0C3);
        step(1'b1, 9'h03C);
        step(1'b1, 9'h0F0);
        repeat (50) step(1'b0, 9'h000);
        tb_rst = 1'b1;
        #1;
        model_reset();
        for (int g = 0; g < NCFG; g++) begin
            check($sformatf("rst_ser[%0d]", g), 32'(w_ser[g]), 1);
            check($sformatf("rst_act[%0d]", g), 32'(w_act[g]), 0);
            check($sformatf("rst_done[%0d]", g), 32'(w_done[g]), 0);
            check($sformatf("rst_cnt[%0d]", g), 32'(w_cnt[g]), 0);
        end
        step(1'b0, 9'h000);
        tb_rst = 1'b0;
        for (int g = 0; g < NCFG; g++) begin
            low_n[g]  = 0;
            done_n[g] = 0;
        end
        repeat (120) begin
            step(1'b0, 9'h000);
            for (int g = 0; g < NCFG; g++) begin
                low_n[g]  += (w_ser[g] == 1'b0) ? 1 : 0;
                done_n[g] += int'(w_done[g]);
            end
        end
        for (int g = 0; g < NCFG; g++) begin
            check($sformatf("post_rst_low[%0d]", g), 32'(low_n[g]), 0);
            check($sformatf("post_rst_done[%0d]", g), 32'(done_n[g]), 0);
        end

        // Random traffic with occasional resets
        repeat (3000) begin
            if ($urandom_range(0, 999) == 0) begin
                tb_rst = 1'b1;
                step(1'b0, 9'h000);
                tb_rst = 1'b0;
            end else begin
                step($urandom_range(0, 6) == 0, 9'($urandom));
            end
        end
        repeat (250) step(1'b0, 9'h000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised successor to the team's single-byte UART transmitter. Configurable data width, parity mode and stop-bit count, with an internal transmit FIFO so producers can queue frames. Frames stream back-to-back with no idle gap while the FIFO holds data. Sits between a byte producer (CPU/bus bridge) and the TX pad.

Parameters:
CLKS_PER_BIT, 5208, clock cycles per serial bit; legal range ≥ 2; baud counter sized by $clog2(CLKS_PER_BIT).
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame; 1 or 2.
FIFO_DEPTH, 4, TX FIFO entries; power of two, ≥ 2.

Ports:
i_Clock  in  1  system clock, rising-edge.
i_Reset  in  1  asynchronous, active-high reset.
i_Tx_DV  in  1  write strobe; pushes i_Tx_Byte when o_Tx_Ready = 1.
i_Tx_Byte  in  DATA_BITS  frame data, LSB transmitted first.
o_Tx_Ready  out  1  FIFO not full (count < FIFO_DEPTH); combinational from count.
o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
o_Tx_Serial  out  1  serial line; idle high.
o_Tx_Active  out  1  high from the START entry edge to the end of the last stop bit.
o_Tx_Done  out  1  one-cycle pulse per completed frame.

Behaviour:
- Reset values (asynchronous, while i_Reset = 1): o_Tx_Serial = 1, o_Tx_Active = 0, o_Tx_Done = 0, FIFO empty (count 0, pointers 0), FSM in IDLE, counters 0.
- Reset asserted mid-frame aborts the frame immediately. The line goes high at once, and queued entries are discarded.
- FIFO write: on a rising edge with i_Tx_DV = 1 and o_Tx_Ready = 1. A write while full is dropped silently, and FIFO contents are unchanged.
- FIFO pop: occurs on the edge where the FSM leaves IDLE or STOP into START.
- Simultaneous push and pop: count is unchanged. When full, push legality is judged on the pre-edge count, so the write is dropped.
- FSM states:
  - IDLE: line = 1. If count > 0: pop the head into the shift register, compute parity, set o_Tx_Active = 1, go to START.
  - START: line = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: line = data[bit_idx], bit_idx 0..DATA_BITS-1, each bit held CLKS_PER_BIT cycles. After the last bit, go to PARITY if PARITY ≠ 0, otherwise STOP.
  - PARITY: line = parity bit for CLKS_PER_BIT cycles, then go to STOP.
    - Even mode: parity bit = XOR of the data bits.
    - Odd mode: parity bit = its inverse.
  - STOP: line = 1 for STOP_BITS × CLKS_PER_BIT cycles. On the final cycle, pulse o_Tx_Done for one cycle.
    - If count > 0: pop and go directly to START; o_Tx_Active stays 1.
    - Otherwise: clear o_Tx_Active and go to IDLE.
- Latency: a write at edge E0 into an empty FIFO with the FSM in IDLE gives o_Tx_Serial = 0 from edge E1.
- Frame length: (1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS) × CLKS_PER_BIT cycles exactly.
- Back-to-back frames: no idle cycles between the stop bit of one frame and the start bit of the next.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. Its width is derived from the parameter, so it never truncates at large CLKS_PER_BIT.
- Illegal state encodings: recover to IDLE on the next edge.

Test Plan:
- Configuration: CLKS_PER_BIT = 4, 8N1. Write 0xA5 once → from E1 the line reads 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. o_Tx_Done pulses once, 40 cycles after E1. o_Tx_Active is high for exactly those 40 cycles.
- Configuration: PARITY = 2 (even). Send 0xA5 → parity bit 0. Rebuild with PARITY = 1 (odd) → parity bit 1. Frame length is 44 cycles.
- Configuration: DATA_BITS = 7, STOP_BITS = 2. Send 0x55 → line reads 0,1,0,1,0,1,0,1,1,1. The frame is 40 cycles, with 8 stop cycles.
- Burst: write 0x01, 0x02, 0x03, 0x04, 0x05 on consecutive cycles with FIFO_DEPTH = 4.
  - o_Tx_Ready drops once the FIFO is full.
  - The fifth byte is dropped only if the FIFO is still full at its write edge; the bench checks against o_Fifo_Count.
  - Frames emit back-to-back with no high gap beyond the stop bits, and there are exactly as many o_Tx_Done pulses as accepted writes.
- Simultaneous push and pop on the STOP→START edge → o_Fifo_Count is unchanged and data order is preserved.
- Assert i_Reset for 1 cycle in the middle of the DATA bits of the second of 3 queued frames.
  - o_Tx_Serial goes to 1 immediately (before the next edge), and o_Tx_Active and o_Tx_Done go to 0.
  - o_Fifo_Count goes to 0, and no further frames are sent.
